countdown_timer_bcd: RTL

- Consumes the 1 Hz square wave from the 100 MHz to 1 Hz clock divider.
- Rising-edge-detects that wave in the clk_in domain and runs an MM:SS BCD countdown with load, start, pause and clear controls.
- Provides digit values for the display path, plus a one-cycle done pulse and an expired level for the alarm/LED logic.

---
 rtl/countdown_timer_bcd_if.sv | 23 ++
 rtl/countdown_timer_bcd.sv | 88 ++++++++
 2 files changed

// File: rtl/countdown_timer_bcd_if.sv
// countdown_timer_bcd_if: control, preset and display signals of the BCD countdown timer
interface countdown_timer_bcd_if;
  logic       tick_src;
  logic       load;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       expired;
  modport master (
    output tick_src, load, preset_min, preset_sec, start, pause, clear,
    input  min_bcd, sec_bcd, running, done, expired
  );
  modport slave (
    input  tick_src, load, preset_min, preset_sec, start, pause, clear,
    output min_bcd, sec_bcd, running, done, expired
  );
endinterface

// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd: MM:SS BCD countdown driven by rising edges of a 1 Hz wave
module countdown_timer_bcd #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic clk_in,
  input logic reset,
  countdown_timer_bcd_if.slave tmr
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSE   = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;
  logic [1:0] state_q, state_d;
  logic [7:0] min_q, min_d, sec_q, sec_d, rmin_q, rmin_d, rsec_q, rsec_d;
  logic       tick_q, done_q, done_d;
  logic       sec_tick, nonzero, term;
  logic [7:0] min_nx, sec_nx, min_san, sec_san;
  logic [3:0] st_clamp;
  function automatic logic [3:0] nib9(input logic [3:0] n);
    return n > 4'd9 ? 4'd9 : n;
  endfunction
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return v[3:0] != 4'd0 ? v - 8'd1 : v[7:4] != 4'd0 ? {v[7:4] - 4'd1, 4'd9} : v;
  endfunction
  assign sec_tick = tmr.tick_src & ~tick_q;
  assign nonzero  = (min_q != 8'h00) || (sec_q != 8'h00);
  assign sec_nx   = sec_q != 8'h00 ? bcd_dec(sec_q) : (min_q != 8'h00 ? 8'h59 : sec_q);
  assign min_nx   = (sec_q == 8'h00) ? bcd_dec(min_q) : min_q;
  assign term     = nonzero && min_nx == 8'h00 && sec_nx == 8'h00;
  assign st_clamp = nib9(tmr.preset_sec[7:4]);
  assign min_san  = {nib9(tmr.preset_min[7:4]), nib9(tmr.preset_min[3:0])};
  assign sec_san  = {st_clamp > 4'd5 ? 4'd5 : st_clamp, nib9(tmr.preset_sec[3:0])};
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    rmin_d  = rmin_q;
    rsec_d  = rsec_q;
    done_d  = 1'b0;
    if (tmr.clear) begin
      state_d = IDLE;
      min_d   = 8'h00;
      sec_d   = 8'h00;
      rmin_d  = 8'h00;
      rsec_d  = 8'h00;
    end else if (tmr.load && state_q != RUN) begin
      state_d = IDLE;
      min_d   = min_san;
      sec_d   = sec_san;
      rmin_d  = min_san;
      rsec_d  = sec_san;
    end else if (tmr.start && (state_q == IDLE || state_q == PAUSE) && nonzero) begin
      state_d = RUN;
    end else if (tmr.pause && state_q == RUN) begin
      state_d = PAUSE;
    end else if (sec_tick && state_q == RUN) begin
      // terminal count either reloads and keeps running, or parks at 00:00
      done_d  = term;
      min_d   = term && AUTO_RELOAD ? rmin_q : min_nx;
      sec_d   = term && AUTO_RELOAD ? rsec_q : sec_nx;
      state_d = term && !AUTO_RELOAD ? EXPIRED : RUN;
    end
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      rmin_q  <= 8'h00;
      rsec_q  <= 8'h00;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      rmin_q  <= rmin_d;
      rsec_q  <= rsec_d;
      tick_q  <= tmr.tick_src;
      done_q  <= done_d;
    end
  end
  assign tmr.min_bcd = min_q;
  assign tmr.sec_bcd = sec_q;
  assign tmr.running = state_q == RUN;
  assign tmr.expired = state_q == EXPIRED;
  assign tmr.done    = done_q;
endmodule
